nibble_shuffle_ctrl: RTL and testbench
======================================

Name: nibble_shuffle_ctrl

Overview:
Sequencer that drives the 4-lane nibble selector so it builds a full 32-bit nibble shuffle of two 32-bit operands. Each request carries DATA_A, DATA_B and eight 4-bit nibble codes. The block runs two selector passes (output nibbles 0-3, then 4-7) and assembles the 32-bit RESULT. It sits between a valid/ready request source and the selector, and owns all selector control inputs.

Parameters:
SEL_LAT, 1, selector latency in cycles from stable DATA/sel/SEL to valid NIBBLE_OUT (0 = combinational; legal range 0-7)

Ports:
CLK  input  1  clock
RESET_L  input  1  asynchronous active-low reset
IN_VALID  input  1  request valid
IN_READY  output  1  request accepted when IN_VALID & IN_READY at posedge CLK
IN_DATA_A  input  32  operand A
IN_DATA_B  input  32  operand B
IN_CTRL  input  32  code k in IN_CTRL[4k+3:4k]: bit3 = source (0 A, 1 B), bits2:0 = nibble index
DATA_A  output  32  to selector, operand A
DATA_B  output  32  to selector, operand B
sel_A  output  [3:0][2:0]  to selector, per-lane A nibble index
sel_B  output  [3:0][2:0]  to selector, per-lane B nibble index
SEL  output  4  to selector, per lane: 0 takes A, 1 takes B
NIBBLE_OUT  input  [3:0][3:0]  from selector; lane i = SEL[i] ? DATA_B nibble sel_B[i] : DATA_A nibble sel_A[i]
OUT_VALID  output  1  RESULT valid
OUT_READY  input  1  result consumed when OUT_VALID & OUT_READY at posedge CLK
RESULT  output  32  shuffled word; RESULT[4k+3:4k] = nibble chosen by code k
BUSY  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync-safe release): state IDLE, cnt 0; DATA_A, DATA_B, sel_A, sel_B, SEL, RESULT, OUT_VALID, BUSY = 0; IN_READY = 1 once in IDLE.
- States: IDLE, PASS0, PASS1, DONE.
- IDLE: IN_READY=1. On accept: register IN_DATA_A->DATA_A, IN_DATA_B->DATA_B, latch IN_CTRL; go PASS0, cnt=0.
- PASS0 / PASS1 (p=0/1): for lane i, code c = CTRL[4(4p+i)+3 : 4(4p+i)]. Drive SEL[i]=c[3], sel_A[i]=sel_B[i]=c[2:0]. Controls stay stable for the whole pass.
- Each edge in a pass: if cnt==SEL_LAT, capture NIBBLE_OUT lane i into RESULT nibble 4p+i, clear cnt, advance (PASS0->PASS1, PASS1->DONE). Otherwise cnt++.
- Each pass lasts SEL_LAT+1 cycles. OUT_VALID rises 2*(SEL_LAT+1) edges after the accept edge (4 for default).
- DONE: OUT_VALID=1, RESULT held, DATA_A/DATA_B held, sel_A/sel_B/SEL=0. On OUT_READY: OUT_VALID=0, go IDLE. The next accept is possible on the following edge.
- IN_READY=0 in PASS0, PASS1 and DONE. No queuing; IN_VALID is ignored while busy.
- OUT_READY asserted outside DONE has no effect. OUT_VALID never drops without a handshake.
- RESULT nibbles not yet captured keep their previous value until overwritten. RESULT stays stable while OUT_VALID=1.
- Reset mid-operation: immediately returns to reset values. The in-flight request is dropped; no OUT_VALID follows.
- The selector is not modelled inside this block. Bench pairs it with a selector model honouring the lane equation with SEL_LAT delay.

Test Plan:
- Mixed shuffle: DATA_A=0x00000FFF, DATA_B=0x0000ABCD, CTRL=0x3210BA98 -> RESULT=0x0FFFABCD; OUT_VALID 4 cycles after accept.
- Reverse: DATA_A=0x76543210, DATA_B=0, CTRL=0x01234567 -> RESULT=0x01234567. During PASS0: SEL=0, sel_A={4,5,6,7} (lane3..0).
- Broadcast: DATA_B=0xE0000000, CTRL=0xFFFFFFFF -> SEL=4'hF in both passes, RESULT=0xEEEEEEEE.
- Backpressure: OUT_READY=0 for 5 cycles with IN_VALID=1 and new data -> OUT_VALID, RESULT, IN_READY=0 all held; second request accepted only on the edge after the OUT handshake, then its correct result.
- Reset in PASS1: drop RESET_L mid-pass -> all outputs 0 asynchronously; after release IN_READY=1, BUSY=0, no spurious OUT_VALID.
- Latency sweep: SEL_LAT=0 and SEL_LAT=2 with the mixed-shuffle vector -> OUT_VALID after 2 and 6 edges, RESULT=0x0FFFABCD both.

Source files
------------

// File: rtl/nibble_shuffle_ctrl.sv
// Sequencer that drives a 4-lane nibble selector through two passes and
// assembles a full 32-bit nibble shuffle of two operands.
module nibble_shuffle_ctrl #(
   parameter int unsigned SEL_LAT = 1
) (
   input  logic            CLK,
   input  logic            RESET_L,
   input  logic            IN_VALID,
   output logic            IN_READY,
   input  logic [31:0]     IN_DATA_A,
   input  logic [31:0]     IN_DATA_B,
   input  logic [31:0]     IN_CTRL,
   output logic [31:0]     DATA_A,
   output logic [31:0]     DATA_B,
   output logic [3:0][2:0] sel_A,
   output logic [3:0][2:0] sel_B,
   output logic [3:0]      SEL,
   input  logic [3:0][3:0] NIBBLE_OUT,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [31:0]     RESULT,
   output logic            BUSY,
   output logic [1:0]      DBG_STATE
);

   // Handshakes: a transfer happens on a rising CLK edge where valid and
   // ready are both high; valid never drops until that edge has occurred.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS0 = 2'd1,
      PASS1 = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [2:0] LAT = 3'(SEL_LAT);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] data_a_q, data_a_d;
   logic [31:0] data_b_q, data_b_d;
   logic [31:0] ctrl_q, ctrl_d;
   logic [31:0] result_q, result_d;
   logic [15:0] codes;

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         data_a_q <= '0;
         data_b_q <= '0;
         ctrl_q   <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_a_q <= data_a_d;
         data_b_q <= data_b_d;
         ctrl_q   <= ctrl_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_a_d  = data_a_q;
      data_b_d  = data_b_q;
      ctrl_d    = ctrl_q;
      result_d  = result_q;
      IN_READY  = 1'b0;
      OUT_VALID = 1'b0;
      SEL       = '0;
      sel_A     = '0;
      sel_B     = '0;
      // Low half of the code word feeds pass 0, high half feeds pass 1.
      codes     = (state_q == PASS1) ? ctrl_q[31:16] : ctrl_q[15:0];

      case (state_q)
         IDLE: begin
            IN_READY = 1'b1;
            if (IN_VALID) begin
               data_a_d = IN_DATA_A;
               data_b_d = IN_DATA_B;
               ctrl_d   = IN_CTRL;
               cnt_d    = '0;
               state_d  = PASS0;
            end
         end
         PASS0, PASS1: begin
            for (int i = 0; i < 4; i++) begin
               SEL[i]   = codes[4*i+3];
               sel_A[i] = codes[4*i +: 3];
               sel_B[i] = codes[4*i +: 3];
            end
            if (cnt_q == LAT) begin
               cnt_d = '0;
               if (state_q == PASS0) begin
                  result_d[15:0] = NIBBLE_OUT;
                  state_d        = PASS1;
               end else begin
                  result_d[31:16] = NIBBLE_OUT;
                  state_d         = DONE;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         DONE: begin
            OUT_VALID = 1'b1;
            if (OUT_READY) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign DATA_A    = data_a_q;
   assign DATA_B    = data_b_q;
   assign RESULT    = result_q;
   assign BUSY      = (state_q != IDLE);
   assign DBG_STATE = state_q;

endmodule

// File: tb/tb_nibble_shuffle_ctrl.sv
// Bench for nibble_shuffle_ctrl: three instances (SEL_LAT 0,1,2) each paired
// with a selector model that honours the lane equation with SEL_LAT delay.
module tb_nibble_shuffle_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   logic            in_valid  [3];
   logic            in_ready  [3];
   logic            out_valid [3];
   logic            out_ready [3];
   logic            busy      [3];
   logic [31:0]     in_a      [3];
   logic [31:0]     in_b      [3];
   logic [31:0]     in_ctrl   [3];
   logic [31:0]     data_a    [3];
   logic [31:0]     data_b    [3];
   logic [31:0]     result    [3];
   logic [3:0][2:0] sel_a     [3];
   logic [3:0][2:0] sel_b     [3];
   logic [3:0]      sel       [3];
   logic [3:0][3:0] nib       [3];
   logic [1:0]      dbg       [3];

   for (genvar g = 0; g < 3; g++) begin : g_inst
      logic [3:0][3:0] comb_n;

      nibble_shuffle_ctrl #(.SEL_LAT(g)) u_dut (
         .CLK        (clk),
         .RESET_L    (rst_n),
         .IN_VALID   (in_valid[g]),
         .IN_READY   (in_ready[g]),
         .IN_DATA_A  (in_a[g]),
         .IN_DATA_B  (in_b[g]),
         .IN_CTRL    (in_ctrl[g]),
         .DATA_A     (data_a[g]),
         .DATA_B     (data_b[g]),
         .sel_A      (sel_a[g]),
         .sel_B      (sel_b[g]),
         .SEL        (sel[g]),
         .NIBBLE_OUT (nib[g]),
         .OUT_VALID  (out_valid[g]),
         .OUT_READY  (out_ready[g]),
         .RESULT     (result[g]),
         .BUSY       (busy[g]),
         .DBG_STATE  (dbg[g])
      );

      always_comb begin
         for (int i = 0; i < 4; i++) begin
            if (sel[g][i]) comb_n[i] = data_b[g][4*sel_b[g][i] +: 4];
            else           comb_n[i] = data_a[g][4*sel_a[g][i] +: 4];
         end
      end

      if (g == 0) begin : g_comb
         assign nib[g] = comb_n;
      end else begin : g_pipe
         logic [3:0][3:0] pipe [0:g-1];
         always @(posedge clk) begin
            pipe[0] <= comb_n;
            for (int s = 1; s < g; s++) pipe[s] <= pipe[s-1];
         end
         assign nib[g] = pipe[g-1];
      end
   end

   function automatic logic [31:0] shuffle_model(input logic [31:0] a, input logic [31:0] b,
                                                 input logic [31:0] c);
      logic [31:0] r;
      logic [3:0]  code;
      logic [31:0] src;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         code = c[4*k +: 4];
         src  = code[3] ? b : a;
         r[4*k +: 4] = src[4*code[2:0] +: 4];
      end
      return r;
   endfunction

   task automatic send_req(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] exp);
      int n;
      n = 0;
      in_a[k] = a; in_b[k] = b; in_ctrl[k] = c; in_valid[k] = 1'b1;
      while (in_ready[k] !== 1'b1 && n < 50) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (in_ready[k] !== 1'b1) begin
         errors++;
         $display("FAIL accept_wait inst%0d: in_ready=%b required 1", k, in_ready[k]);
      end
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      exp_q.push_back(exp);
   endtask

   task automatic wait_result(input int k, input logic [31:0] c);
      int n;
      logic [15:0] codes;
      logic [3:0] es;
      logic [3:0][2:0] esa;
      logic [31:0] exp;
      n = 0;
      while (n <= 50) begin
         if (n == 0 || n == k + 1) begin
            codes = (n == 0) ? c[15:0] : c[31:16];
            for (int i = 0; i < 4; i++) begin
               es[i]  = codes[4*i+3];
               esa[i] = codes[4*i +: 3];
            end
            checks++;
            if (sel[k] !== es || sel_a[k] !== esa || sel_b[k] !== esa || busy[k] !== 1'b1) begin
               errors++;
               $display("FAIL pass_ctrl inst%0d edge%0d: SEL=%h sel_A=%h sel_B=%h busy=%b required SEL=%h sel=%h busy=1",
                        k, n, sel[k], sel_a[k], sel_b[k], busy[k], es, esa);
            end
         end
         if (out_valid[k] === 1'b1) break;
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n != 2 * (k + 1)) begin
         errors++;
         $display("FAIL latency inst%0d: out_valid after %0d edges required %0d", k, n, 2 * (k + 1));
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      checks++;
      if (result[k] !== exp) begin
         errors++;
         $display("FAIL result inst%0d: got %h required %h", k, result[k], exp);
      end
      checks++;
      if (sel[k] !== 4'h0 || sel_a[k] !== 12'h0 || sel_b[k] !== 12'h0 || in_ready[k] !== 1'b0) begin
         errors++;
         $display("FAIL done_ctrl inst%0d: SEL=%h sel_A=%h sel_B=%h in_ready=%b required all 0",
                  k, sel[k], sel_a[k], sel_b[k], in_ready[k]);
      end
   endtask

   task automatic ack(input int k);
      out_ready[k] = 1'b1;
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
      checks++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
         errors++;
         $display("FAIL ack inst%0d: out_valid=%b in_ready=%b busy=%b required 0/1/0",
                  k, out_valid[k], in_ready[k], busy[k]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || result[k] !== 32'h0 ||
             data_a[k] !== 32'h0 || data_b[k] !== 32'h0 || sel[k] !== 4'h0 ||
             sel_a[k] !== 12'h0 || sel_b[k] !== 12'h0) begin
            errors++;
            $display("FAIL reset_vals inst%0d: out_valid=%b busy=%b result=%h data_a=%h sel=%h",
                     k, out_valid[k], busy[k], result[k], data_a[k], sel[k]);
         end
      end
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (in_ready[k] !== 1'b1 || busy[k] !== 1'b0 || out_valid[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_release inst%0d: in_ready=%b busy=%b out_valid=%b required 1/0/0",
                     k, in_ready[k], busy[k], out_valid[k]);
         end
      end
   endtask

   task automatic test_mixed();
      send_req(1, 32'h00000FFF, 32'h0000ABCD, 32'h3210BA98, 32'h0FFFABCD);
      wait_result(1, 32'h3210BA98);
      ack(1);
   endtask

   task automatic test_reverse();
      send_req(1, 32'h76543210, 32'h0, 32'h01234567, 32'h01234567);
      wait_result(1, 32'h01234567);
      ack(1);
   endtask

   task automatic test_broadcast();
      send_req(1, 32'h0, 32'hE0000000, 32'hFFFFFFFF, 32'hEEEEEEEE);
      wait_result(1, 32'hFFFFFFFF);
      ack(1);
   endtask

   task automatic test_random();
      logic [31:0] a, b, c;
      for (int t = 0; t < 6; t++) begin
         a = $urandom; b = $urandom; c = $urandom;
         send_req(1, a, b, c, shuffle_model(a, b, c));
         wait_result(1, c);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid[1] !== 1'b1) begin
               errors++;
               $display("FAIL hold_valid inst1: out_valid=%b required 1", out_valid[1]);
            end
         end
         ack(1);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] held;
      send_req(1, 32'h00000FFF, 32'h0000ABCD, 32'h3210BA98, 32'h0FFFABCD);
      wait_result(1, 32'h3210BA98);
      held = result[1];
      in_a[1] = 32'h76543210; in_b[1] = 32'h0; in_ctrl[1] = 32'h01234567;
      in_valid[1] = 1'b1;
      for (int t = 0; t < 5; t++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid[1] !== 1'b1 || result[1] !== held || in_ready[1] !== 1'b0 || busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL backpressure cyc%0d: out_valid=%b result=%h in_ready=%b required 1/%h/0",
                     t, out_valid[1], result[1], in_ready[1], held);
         end
      end
      ack(1);
      send_req(1, 32'h76543210, 32'h0, 32'h01234567, 32'h01234567);
      wait_result(1, 32'h01234567);
      ack(1);
   endtask

   task automatic test_reset_mid();
      logic seen;
      send_req(1, 32'h0, 32'hE0000000, 32'hFFFFFFFF, 32'hEEEEEEEE);
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (dbg[1] !== 2'd2) begin
         errors++;
         $display("FAIL reach_pass1: state=%0d required 2", dbg[1]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid[1] !== 1'b0 || busy[1] !== 1'b0 || result[1] !== 32'h0 || data_a[1] !== 32'h0 ||
          data_b[1] !== 32'h0 || sel[1] !== 4'h0 || sel_a[1] !== 12'h0 || sel_b[1] !== 12'h0) begin
         errors++;
         $display("FAIL async_reset: out_valid=%b busy=%b result=%h data_b=%h sel=%h sel_A=%h required all 0",
                  out_valid[1], busy[1], result[1], data_b[1], sel[1], sel_a[1]);
      end
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: in_ready=%b busy=%b required 1/0", in_ready[1], busy[1]);
      end
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (out_valid[1] !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL spurious_out_valid: seen=%b required 0", seen);
      end
   endtask

   task automatic test_latency();
      send_req(0, 32'h00000FFF, 32'h0000ABCD, 32'h3210BA98, 32'h0FFFABCD);
      wait_result(0, 32'h3210BA98);
      ack(0);
      send_req(2, 32'h00000FFF, 32'h0000ABCD, 32'h3210BA98, 32'h0FFFABCD);
      wait_result(2, 32'h3210BA98);
      ack(2);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         in_valid[k] = 1'b0; out_ready[k] = 1'b0;
         in_a[k] = '0; in_b[k] = '0; in_ctrl[k] = '0;
      end
      test_reset();
      test_mixed();
      test_reverse();
      test_broadcast();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_latency();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
